// File: rtl/blackbox_pkg.sv
// Shared types and defaults for the blackbox lab slice.
package blackbox_pkg;

  localparam int unsigned BB_N_IN           = 3;
  localparam int unsigned BB_SETTLE_DEFAULT = 2;
  localparam int unsigned BB_CNT_W          = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } sweep_state_t;

endpackage

// File: rtl/blackbox_sweeper.sv
// Walks the blackbox through every input vector, captures its output as a truth
// table and checks the table against a golden table latched at start.
module blackbox_sweeper
  import blackbox_pkg::*;
#(
  parameter int unsigned N_IN          = BB_N_IN,
  parameter int unsigned SETTLE_CYCLES = BB_SETTLE_DEFAULT
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic [(1<<N_IN)-1:0]    expected,
  output logic [N_IN-1:0]         vec,
  input  logic                    a,
  output logic                    busy,
  output logic                    done,
  output logic [(1<<N_IN)-1:0]    table_out,
  output logic [(1<<N_IN)-1:0]    mismatch,
  output logic                    pass
);

  localparam int unsigned TBL_W = 1 << N_IN;
  localparam logic [BB_CNT_W-1:0] LAST_CNT = BB_CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [N_IN-1:0]     LAST_IDX = N_IN'(TBL_W - 1);

  sweep_state_t          state_q, state_d;
  logic [N_IN-1:0]       idx_q, idx_d;
  logic [BB_CNT_W-1:0]   cnt_q, cnt_d;
  logic [TBL_W-1:0]      exp_q, exp_d;
  logic [TBL_W-1:0]      table_q, table_d;
  logic [TBL_W-1:0]      mis_q, mis_d;
  logic                  pass_q, pass_d;
  logic [N_IN-1:0]       vec_q, vec_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  // Next-state and next-output logic; outputs are computed for the state being entered.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    exp_d   = exp_q;
    table_d = table_q;
    mis_d   = mis_q;
    pass_d  = pass_q;
    vec_d   = vec_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        vec_d = '0;
        if (start) begin
          exp_d   = expected;
          table_d = '0;
          mis_d   = '0;
          pass_d  = 1'b0;
          idx_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        busy_d = 1'b1;
        cnt_d  = cnt_q + BB_CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          state_d = SAMPLE;
        end
      end
      SAMPLE: begin
        table_d[idx_q] = a;
        if (idx_q == LAST_IDX) begin
          // Compare against the table including the bit captured this cycle.
          vec_d   = '0;
          done_d  = 1'b1;
          mis_d   = table_d ^ exp_q;
          pass_d  = (table_d == exp_q);
          state_d = DONE;
        end else begin
          idx_d   = idx_q + N_IN'(1);
          cnt_d   = '0;
          vec_d   = idx_q + N_IN'(1);
          busy_d  = 1'b1;
          state_d = SETTLE;
        end
      end
      DONE: begin
        vec_d   = '0;
        state_d = IDLE;
      end
      default: begin
        vec_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      exp_q   <= '0;
      table_q <= '0;
      mis_q   <= '0;
      pass_q  <= 1'b0;
      vec_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      exp_q   <= exp_d;
      table_q <= table_d;
      mis_q   <= mis_d;
      pass_q  <= pass_d;
      vec_q   <= vec_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign vec       = vec_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign table_out = table_q;
  assign mismatch  = mis_q;
  assign pass      = pass_q;

endmodule

// File: tb/tb_blackbox_sweeper.sv
// Bench for blackbox_sweeper: two instances (settle 2 and settle 1) driving a
// behavioural blackbox a = (z & k) | r with optional output delay.
`timescale 1ns/1ps
module tb_blackbox_sweeper;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic       start2, start1;
  logic [7:0] exp2, exp1;
  logic [2:0] vec2, vec1;
  logic       a2, a1;
  logic       busy2, busy1, done2, done1, pass2, pass1;
  logic [7:0] tbl2, tbl1, mis2, mis1;

  int   dly;
  bit   use1;
  int   s_cur;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [2:0] v2_p1, v2_p2, v1_p1, v1_p2;
  always @(posedge clk) begin
    v2_p1 <= vec2;
    v2_p2 <= v2_p1;
    v1_p1 <= vec1;
    v1_p2 <= v1_p1;
  end

  function automatic logic bb(input logic [2:0] v);
    return (v[2] & v[1]) | v[0];
  endfunction

  always_comb begin
    a2 = bb((dly == 0) ? vec2 : (dly == 1) ? v2_p1 : v2_p2);
    a1 = bb((dly == 0) ? vec1 : (dly == 1) ? v1_p1 : v1_p2);
  end

  blackbox_sweeper #(.N_IN(3), .SETTLE_CYCLES(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .start(start2), .expected(exp2), .vec(vec2),
    .a(a2), .busy(busy2), .done(done2), .table_out(tbl2), .mismatch(mis2), .pass(pass2)
  );

  blackbox_sweeper #(.N_IN(3), .SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .start(start1), .expected(exp1), .vec(vec1),
    .a(a1), .busy(busy1), .done(done1), .table_out(tbl1), .mismatch(mis1), .pass(pass1)
  );

  logic [2:0] o_vec;
  logic       o_busy, o_done, o_pass;
  logic [7:0] o_tbl, o_mis;
  always_comb begin
    o_vec  = use1 ? vec1  : vec2;
    o_busy = use1 ? busy1 : busy2;
    o_done = use1 ? done1 : done2;
    o_pass = use1 ? pass1 : pass2;
    o_tbl  = use1 ? tbl1  : tbl2;
    o_mis  = use1 ? mis1  : mis2;
  end

  // Expected captured table: the sample for vector i is taken in the last held
  // cycle, and a delayed blackbox reports the vector from d cycles earlier.
  function automatic logic [7:0] ref_table(input int s, input int d);
    logic [7:0] t;
    int c, v;
    t = '0;
    for (int i = 0; i < 8; i++) begin
      c = (i + 1) * (s + 1) - 1 - d;
      v = (c < 0) ? 0 : c / (s + 1);
      t[i] = bb(3'(v));
    end
    return t;
  endfunction

  task automatic drive_start(input logic v);
    if (use1) start1 = v;
    else start2 = v;
  endtask

  // Issue one start and follow the sweep until done (bounded), recording observations.
  task automatic run_sweep(input logic [7:0] exp, input bit hold, output int lat,
                           output logic [7:0] tbl, output logic [7:0] mis,
                           output logic pss, output int vec_bad, output int busy_bad);
    @(negedge clk);
    if (use1) exp1 = exp;
    else exp2 = exp;
    drive_start(1'b1);
    @(posedge clk);
    #1;
    if (!hold) drive_start(1'b0);
    lat = -1; vec_bad = 0; busy_bad = 0;
    tbl = '0; mis = '0; pss = 1'b0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (o_done === 1'b1) begin
        lat = t; tbl = o_tbl; mis = o_mis; pss = o_pass;
        if (o_busy !== 1'b0) busy_bad++;
        break;
      end
      if (o_vec !== 3'(t / (s_cur + 1))) vec_bad++;
      if (o_busy !== 1'b1) busy_bad++;
    end
  endtask

  task automatic test_reset();
    n_cmp++; if (vec2 !== 3'd0) begin n_bad++; $display("FAIL reset_vec: got %h want 0", vec2); end
    n_cmp++; if (busy2 !== 1'b0 || busy1 !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b%b want 00", busy2, busy1); end
    n_cmp++; if (done2 !== 1'b0 || done1 !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b%b want 00", done2, done1); end
    n_cmp++; if (tbl2 !== 8'h00 || mis2 !== 8'h00 || pass2 !== 1'b0) begin
      n_bad++; $display("FAIL reset_results: got tbl=%h mis=%h pass=%b want 00/00/0", tbl2, mis2, pass2); end
  endtask

  task automatic test_basic();
    int lat, vb, bb_n; logic [7:0] tbl, mis; logic pss;
    use1 = 0; s_cur = 2; dly = 0;
    run_sweep(8'hEA, 1'b0, lat, tbl, mis, pss, vb, bb_n);
    n_cmp++; if (lat !== 24) begin n_bad++; $display("FAIL basic_latency: got %0d want 24", lat); end
    n_cmp++; if (vb !== 0) begin n_bad++; $display("FAIL basic_vec_steps: got %0d bad cycles want 0", vb); end
    n_cmp++; if (bb_n !== 0) begin n_bad++; $display("FAIL basic_busy: got %0d bad cycles want 0", bb_n); end
    n_cmp++; if (tbl !== ref_table(2, 0)) begin n_bad++; $display("FAIL basic_table: got %h want %h", tbl, ref_table(2, 0)); end
    n_cmp++; if (mis !== 8'h00 || pss !== 1'b1) begin n_bad++; $display("FAIL basic_pass: got mis=%h pass=%b want 00/1", mis, pss); end
    repeat (4) @(negedge clk);
    n_cmp++; if (tbl2 !== 8'hEA || pass2 !== 1'b1 || done2 !== 1'b0 || busy2 !== 1'b0) begin
      n_bad++; $display("FAIL basic_hold: got tbl=%h pass=%b done=%b busy=%b want EA/1/0/0", tbl2, pass2, done2, busy2); end
  endtask

  task automatic test_mismatch();
    int lat, vb, bb_n; logic [7:0] tbl, mis; logic pss;
    use1 = 0; s_cur = 2; dly = 0;
    run_sweep(8'hEB, 1'b0, lat, tbl, mis, pss, vb, bb_n);
    n_cmp++; if (tbl !== 8'hEA) begin n_bad++; $display("FAIL mm_table: got %h want EA", tbl); end
    n_cmp++; if (mis !== 8'h01) begin n_bad++; $display("FAIL mm_mismatch: got %h want 01", mis); end
    n_cmp++; if (pss !== 1'b0) begin n_bad++; $display("FAIL mm_pass: got %b want 0", pss); end
  endtask

  task automatic test_random();
    int lat, vb, bb_n; logic [7:0] tbl, mis, e, rt; logic pss;
    dly = 0;
    for (int k = 0; k < 6; k++) begin
      use1 = ($urandom_range(0, 1) == 1);
      s_cur = use1 ? 1 : 2;
      rt = ref_table(s_cur, 0);
      e = ($urandom_range(0, 2) == 0) ? rt : 8'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_sweep(e, 1'b0, lat, tbl, mis, pss, vb, bb_n);
      n_cmp++; if (lat !== 8 * (s_cur + 1) || vb !== 0) begin
        n_bad++; $display("FAIL rand_timing[%0d]: got lat=%0d vecbad=%0d want %0d/0", k, lat, vb, 8 * (s_cur + 1)); end
      n_cmp++; if (tbl !== rt || mis !== (rt ^ e) || pss !== (rt == e)) begin
        n_bad++; $display("FAIL rand_result[%0d]: got tbl=%h mis=%h pass=%b want %h/%h/%b", k, tbl, mis, pss, rt, rt ^ e, rt == e); end
    end
  endtask

  task automatic test_back_to_back();
    int lat, vb, bb_n, dones, t2; logic [7:0] tbl, mis; logic pss;
    use1 = 0; s_cur = 2; dly = 0;
    run_sweep(8'hEA, 1'b1, lat, tbl, mis, pss, vb, bb_n);
    n_cmp++; if (lat !== 24 || vb !== 0 || bb_n !== 0) begin
      n_bad++; $display("FAIL b2b_first: got lat=%0d vecbad=%0d busybad=%0d want 24/0/0", lat, vb, bb_n); end
    @(negedge clk);
    n_cmp++; if (busy2 !== 1'b0 || vec2 !== 3'd0) begin n_bad++; $display("FAIL b2b_idle_gap: got busy=%b vec=%h want 0/0", busy2, vec2); end
    @(negedge clk);
    n_cmp++; if (busy2 !== 1'b1) begin n_bad++; $display("FAIL b2b_restart: got busy=%b want 1", busy2); end
    start2 = 1'b0;
    dones = 0; t2 = -1;
    for (int t = 1; t < 40; t++) begin
      @(negedge clk);
      if (done2 === 1'b1) begin dones++; if (t2 < 0) t2 = t; end
    end
    n_cmp++; if (dones !== 1 || t2 !== 24) begin n_bad++; $display("FAIL b2b_second: got dones=%0d at %0d want 1 at 24", dones, t2); end
    n_cmp++; if (tbl2 !== 8'hEA || pass2 !== 1'b1) begin n_bad++; $display("FAIL b2b_second_result: got tbl=%h pass=%b want EA/1", tbl2, pass2); end
  endtask

  task automatic test_reset_mid();
    int lat, vb, bb_n, seen; logic [7:0] tbl, mis; logic pss;
    use1 = 0; s_cur = 2; dly = 0;
    @(negedge clk); exp2 = 8'hEA; start2 = 1'b1;
    @(posedge clk); #1; start2 = 1'b0;
    seen = 0;
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      if (vec2 === 3'd4) begin seen = 1; break; end
    end
    n_cmp++; if (seen !== 1) begin n_bad++; $display("FAIL rstmid_reach_vec4: got %0d want 1", seen); end
    #2 reset_n = 1'b0;
    #1;
    n_cmp++; if (vec2 !== 3'd0 || busy2 !== 1'b0 || done2 !== 1'b0 || tbl2 !== 8'h00 || mis2 !== 8'h00 || pass2 !== 1'b0) begin
      n_bad++; $display("FAIL rstmid_async: got vec=%h busy=%b done=%b tbl=%h mis=%h pass=%b want all 0",
                        vec2, busy2, done2, tbl2, mis2, pass2); end
    @(negedge clk); reset_n = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (busy2 !== 1'b0) begin n_bad++; $display("FAIL rstmid_idle: got busy=%b want 0", busy2); end
    run_sweep(8'hEA, 1'b0, lat, tbl, mis, pss, vb, bb_n);
    n_cmp++; if (lat !== 24 || vb !== 0 || tbl !== 8'hEA || pss !== 1'b1) begin
      n_bad++; $display("FAIL rstmid_resweep: got lat=%0d vecbad=%0d tbl=%h pass=%b want 24/0/EA/1", lat, vb, tbl, pss); end
  endtask

  task automatic test_settle1();
    int lat, vb, bb_n; logic [7:0] tbl, mis; logic pss;
    use1 = 1; s_cur = 1; dly = 0;
    run_sweep(8'hEA, 1'b0, lat, tbl, mis, pss, vb, bb_n);
    n_cmp++; if (lat !== 16) begin n_bad++; $display("FAIL s1_latency: got %0d want 16", lat); end
    n_cmp++; if (vb !== 0 || bb_n !== 0) begin n_bad++; $display("FAIL s1_steps: got vecbad=%0d busybad=%0d want 0/0", vb, bb_n); end
    n_cmp++; if (tbl !== 8'hEA || pss !== 1'b1) begin n_bad++; $display("FAIL s1_result: got tbl=%h pass=%b want EA/1", tbl, pss); end
  endtask

  task automatic test_delayed();
    int lat, vb, bb_n; logic [7:0] tbl, mis, rt; logic pss;
    use1 = 1; s_cur = 1;
    dly = 1;
    repeat (4) @(negedge clk);
    run_sweep(8'hEA, 1'b0, lat, tbl, mis, pss, vb, bb_n);
    n_cmp++; if (tbl !== ref_table(1, 1) || pss !== 1'b1) begin
      n_bad++; $display("FAIL dly1_result: got tbl=%h pass=%b want %h/1", tbl, pss, ref_table(1, 1)); end
    dly = 2;
    repeat (4) @(negedge clk);
    rt = ref_table(1, 2);
    run_sweep(8'hEA, 1'b0, lat, tbl, mis, pss, vb, bb_n);
    n_cmp++; if (tbl !== rt) begin n_bad++; $display("FAIL dly2_table: got %h want %h", tbl, rt); end
    n_cmp++; if (mis !== (rt ^ 8'hEA) || pss !== 1'b0) begin
      n_bad++; $display("FAIL dly2_mismatch: got mis=%h pass=%b want %h/0", mis, pss, rt ^ 8'hEA); end
    dly = 0;
  endtask

  initial begin
    start1 = 1'b0; start2 = 1'b0; exp1 = '0; exp2 = '0;
    dly = 0; use1 = 0; s_cur = 2;
    repeat (3) @(negedge clk);
    test_reset();
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    test_basic();
    test_mismatch();
    test_random();
    test_back_to_back();
    test_reset_mid();
    test_settle1();
    test_delayed();
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/blackbox_sweeper.md
# blackbox_sweeper

Hardware sequencer that exhaustively drives the `blackbox` combinational unit through all input combinations, samples its output `a` for each, and builds a truth table. The captured table is compared against a golden table supplied at start. It sits beside `blackbox` in the Lab1 design and replaces the hand-stepped stimulus loop with an on-chip self-check that reports pass/fail.

## Interface

Parameters:
- `N_IN`, default 3: number of blackbox inputs. The table width is `2**N_IN`.
- `SETTLE_CYCLES`, default 2: cycles each vector is held before sampling. Legal range is 1 to 255.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  request a sweep. Accepted only in IDLE.
- `expected`  in  2**N_IN  golden truth table. Bit i is the expected `a` for vector i. Latched when `start` is accepted.
- `vec`  out  N_IN  drive to blackbox: `vec[2]`=z, `vec[1]`=k, `vec[0]`=r.
- `a`  in  1  blackbox output.
- `busy`  out  1  high from the cycle after `start` is accepted until DONE.
- `done`  out  1  one-cycle pulse when the sweep completes.
- `table_out`  out  2**N_IN  captured truth table.
- `mismatch`  out  2**N_IN  `table_out` XOR latched `expected`.
- `pass`  out  1  high when `mismatch` is all zero. Valid from `done` onward.

## Operation

- Reset values, applied immediately on `reset_n` low: state IDLE; `vec`, `busy`, `done`, `table_out`, `mismatch`, `pass`, index and settle counter all 0; latched `expected` is 0.
- FSM states are IDLE, SETTLE, SAMPLE and DONE.
- IDLE:
  - `vec`=0.
  - When `start`=1, latch `expected`, clear `table_out`/`mismatch`/`pass`, set index to 0 and counter to 0, then go to SETTLE.
- SETTLE:
  - `vec`=index.
  - The counter increments each cycle.
  - When counter == SETTLE_CYCLES-1, go to SAMPLE.
- SAMPLE:
  - `vec`=index.
  - `table_out[index]` <= `a`.
  - If index == 2**N_IN-1, go to DONE. Otherwise increment index, clear the counter and go to SETTLE.
- DONE:
  - `done`=1 for this single cycle.
  - `mismatch` and `pass` are updated from the final table.
  - Return to IDLE.
- `start` is ignored in SETTLE, SAMPLE and DONE. There is no queuing.
- Index arithmetic is N_IN bits wide. The terminal compare prevents wrap-around. Index never exceeds 2**N_IN-1.
- Results hold unchanged in IDLE until the next accepted `start`.
- Reset mid-sweep aborts the sweep. The partial table is discarded (cleared to 0). The next `start` runs a full sweep from vector 0.

## Timing

- Each vector is held for SETTLE_CYCLES+1 cycles. `a` is sampled at the end of the last of those cycles.
- Let edge E0 be the edge that accepts `start`:
  - Vector i is driven from E0+i·(S+1) through E0+(i+1)·(S+1), where S = SETTLE_CYCLES.
  - `done` is high during the cycle following edge E0+2**N_IN·(S+1).
  - With defaults, `done` is asserted 24 cycles after E0.
- `busy` is high during the SETTLE and SAMPLE states only.
- The earliest next accepted `start` is in the cycle after `done`.
- `a` must be stable within S cycles of `vec` changing. The blackbox may be combinational or registered, with up to S cycles of delay.

## Structure

- Shared package `blackbox_pkg` holds:
  - the `sweep_state_t` enum (IDLE, SETTLE, SAMPLE, DONE);
  - the default constants `BB_N_IN`=3 and `BB_SETTLE_DEFAULT`=2.
- No sub-module is needed: the FSM, settle counter, index register and table register all live in one module.
- The top-level lab wrapper instantiates `blackbox` and `blackbox_sweeper` side by side.

## Test plan

All scenarios use a bench model of `a` = (z & k) | r, which gives table 8'hEA.

1. Defaults, `expected`=8'hEA, single `start` pulse.
   - `vec` steps 0..7, each held 3 cycles.
   - `done` pulses 24 cycles after accept.
   - `table_out`=8'hEA, `mismatch`=0, `pass`=1.
2. `expected`=8'hEB.
   - `table_out`=8'hEA, `mismatch`=8'h01, `pass`=0.
3. `start` held high for the whole sweep.
   - Exactly one `done` in 24 cycles, then a second sweep starts the cycle after `done`.
   - No `start` is accepted during SETTLE/SAMPLE/DONE.
4. `reset_n` pulsed low while `vec`=4.
   - All outputs are 0 asynchronously and the FSM is in IDLE.
   - The next `start` completes a full sweep with `table_out`=8'hEA.
5. SETTLE_CYCLES=1.
   - Each vector is held 2 cycles.
   - `done` pulses 16 cycles after accept, with `pass`=1.
6. SETTLE_CYCLES=1 with the model output registered by one cycle.
   - `table_out`=8'hEA.
   - With the model delayed by 2 cycles, `mismatch`≠0 and `pass`=0.
